// File: rtl/system_cpu_oci_trace_packer.sv
// Packs small OCI trace fragments into DCT words and queues them for the trace sink.
// On test_ending, the partial word is flushed and the queue is drained before reporting completion.
module system_cpu_oci_trace_packer #(
    parameter  int FRAG_W         = 2,
    parameter  int FRAGS_PER_WORD = 15,
    parameter  int COUNT_W        = 4,
    parameter  int FIFO_DEPTH     = 4,
    localparam int WORD_W         = FRAG_W * FRAGS_PER_WORD
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_in_valid,
    input  logic [FRAG_W-1:0]  i_in_data,
    output logic               o_in_ready,
    input  logic               i_test_ending,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WORD_W-1:0]  o_out_word,
    output logic [COUNT_W-1:0] o_out_count,
    output logic [WORD_W-1:0]  o_dct_buffer,
    output logic [COUNT_W-1:0] o_dct_count,
    output logic               o_test_has_ended
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FRAGS_PER_WORD);
    localparam logic [COUNT_W-1:0] LAST_SLOT  = COUNT_W'(FRAGS_PER_WORD - 1);
    localparam logic [OCC_W-1:0]   DEPTH_OCC  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WORD_W-1:0]  r_dctBuffer;
    logic [COUNT_W-1:0] r_dctCount;
    logic               r_testHasEnded;

    logic [WORD_W-1:0]  r_fifoWord  [FIFO_DEPTH];
    logic [COUNT_W-1:0] r_fifoCount [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [OCC_W-1:0]   r_occupancy;

    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic               w_wordDone;
    logic               w_flushPush;
    logic [WORD_W-1:0]  w_shifted;
    logic [COUNT_W-1:0] w_countInc;
    logic [WORD_W-1:0]  w_pushWord;
    logic [COUNT_W-1:0] w_pushCount;

    // The last slot of a word is only offered when the completed word has somewhere to go.
    always_comb begin
        w_fifoFull  = (r_occupancy == DEPTH_OCC);
        w_fifoEmpty = (r_occupancy == '0);
        o_in_ready  = (r_state == RUN) && ((r_dctCount < LAST_SLOT) || !w_fifoFull);
        w_accept    = i_in_valid && o_in_ready;
        w_shifted   = (r_dctBuffer << FRAG_W) | WORD_W'(i_in_data);
        w_countInc  = r_dctCount + 1'b1;
        w_wordDone  = w_accept && (w_countInc == FULL_COUNT);
        w_flushPush = (r_state == FLUSH) && (r_dctCount != '0) && !w_fifoFull;
        w_push      = w_wordDone || w_flushPush;
        w_pushWord  = w_wordDone ? w_shifted : r_dctBuffer;
        w_pushCount = w_wordDone ? FULL_COUNT : r_dctCount;
        w_pop       = !w_fifoEmpty && i_out_ready;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dctBuffer <= '0;
            r_dctCount  <= '0;
        end else if (w_push) begin
            r_dctBuffer <= '0;
            r_dctCount  <= '0;
        end else if (w_accept) begin
            r_dctBuffer <= w_shifted;
            r_dctCount  <= w_countInc;
        end
    end

    // Storage needs no reset: entries are only visible while the occupancy covers them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoWord[r_wrPtr]  <= w_pushWord;
            r_fifoCount[r_wrPtr] <= w_pushCount;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occupancy <= r_occupancy + 1'b1;
                2'b01:   r_occupancy <= r_occupancy - 1'b1;
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= RUN;
            r_testHasEnded <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_testHasEnded <= (w_nextState == DONE);
        end
    end

    // A full FIFO holds FLUSH until a pop makes room for the partial word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (i_test_ending) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                if ((r_dctCount == '0) || !w_fifoFull) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifoEmpty) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = DONE;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    always_comb begin
        o_out_valid      = !w_fifoEmpty;
        o_out_word       = w_fifoEmpty ? '0 : r_fifoWord[r_rdPtr];
        o_out_count      = w_fifoEmpty ? '0 : r_fifoCount[r_rdPtr];
        o_dct_buffer     = r_dctBuffer;
        o_dct_count      = r_dctCount;
        o_test_has_ended = r_testHasEnded;
    end

endmodule

// File: tb/tb_system_cpu_oci_trace_packer.sv
// Randomized and directed bench for the OCI trace packer, checked against a queue-based model
// that tracks pending fragments, queued words and the flush/drain progress.
module tb_system_cpu_oci_trace_packer;

    localparam int FW    = 2;
    localparam int FPW   = 15;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int WW    = FW * FPW;

    logic          clk;
    logic          resetN;
    logic          inValid;
    logic [FW-1:0] inData;
    logic          inReady;
    logic          testEnding;
    logic          outValid;
    logic          outReady;
    logic [WW-1:0] outWord;
    logic [CW-1:0] outCount;
    logic [WW-1:0] dctBuffer;
    logic [CW-1:0] dctCount;
    logic          testHasEnded;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic [WW-1:0] word;
        int            count;
    } entry_t;

    entry_t        mWords[$];
    logic [FW-1:0] mFrags[$];
    bit            mEnding;
    bit            mDraining;
    bit            mDone;

    system_cpu_oci_trace_packer #(
        .FRAG_W         (FW),
        .FRAGS_PER_WORD (FPW),
        .COUNT_W        (CW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (resetN),
        .i_in_valid       (inValid),
        .i_in_data        (inData),
        .o_in_ready       (inReady),
        .i_test_ending    (testEnding),
        .o_out_valid      (outValid),
        .i_out_ready      (outReady),
        .o_out_word       (outWord),
        .o_out_count      (outCount),
        .o_dct_buffer     (dctBuffer),
        .o_dct_count      (dctCount),
        .o_test_has_ended (testHasEnded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation exceeded time limit");
    end

    // Counts every comparison and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // First fragment ends up most significant: fold the pending fragments as base-2^FW digits.
    function automatic logic [WW-1:0] packFrags();
        logic [WW-1:0] acc;
        acc = '0;
        foreach (mFrags[i]) begin
            acc = WW'(acc * (1 << FW) + mFrags[i]);
        end
        return acc;
    endfunction

    function automatic bit modelInReady();
        return !mEnding && ((mFrags.size() < FPW - 1) || (mWords.size() < DEPTH));
    endfunction

    task automatic modelReset();
        mWords.delete();
        mFrags.delete();
        mEnding   = 1'b0;
        mDraining = 1'b0;
        mDone     = 1'b0;
    endtask

    // Advances the model by one clock edge given the inputs present before that edge.
    task automatic modelStep(input bit valid, input logic [FW-1:0] data, input bit ending, input bit rdy);
        int     preWords;
        bit     accept;
        entry_t e;
        preWords = mWords.size();
        accept   = valid && modelInReady();
        if (preWords > 0 && rdy) begin
            void'(mWords.pop_front());
        end
        if (!mEnding) begin
            if (accept) begin
                mFrags.push_back(data);
                if (mFrags.size() == FPW) begin
                    e.word  = packFrags();
                    e.count = FPW;
                    mWords.push_back(e);
                    mFrags.delete();
                end
            end
            if (ending) begin
                mEnding = 1'b1;
            end
        end else if (!mDraining) begin
            if (mFrags.size() == 0) begin
                mDraining = 1'b1;
            end else if (preWords < DEPTH) begin
                e.word  = packFrags();
                e.count = mFrags.size();
                mWords.push_back(e);
                mFrags.delete();
                mDraining = 1'b1;
            end
        end else if (!mDone) begin
            if (preWords == 0) begin
                mDone = 1'b1;
            end
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".in_ready"}, 64'(inReady), 64'(modelInReady()));
        checkOutput({where, ".out_valid"}, 64'(outValid), 64'(mWords.size() > 0));
        if (mWords.size() > 0) begin
            checkOutput({where, ".out_word"}, 64'(outWord), 64'(mWords[0].word));
            checkOutput({where, ".out_count"}, 64'(outCount), 64'(mWords[0].count));
        end
        checkOutput({where, ".dct_buffer"}, 64'(dctBuffer), 64'(packFrags()));
        checkOutput({where, ".dct_count"}, 64'(dctCount), 64'(mFrags.size()));
        checkOutput({where, ".test_has_ended"}, 64'(testHasEnded), 64'(mDone));
    endtask

    task automatic checkResetValues(input string where);
        checkOutput({where, ".out_valid"}, 64'(outValid), 64'd0);
        checkOutput({where, ".out_word"}, 64'(outWord), 64'd0);
        checkOutput({where, ".out_count"}, 64'(outCount), 64'd0);
        checkOutput({where, ".dct_buffer"}, 64'(dctBuffer), 64'd0);
        checkOutput({where, ".dct_count"}, 64'(dctCount), 64'd0);
        checkOutput({where, ".test_has_ended"}, 64'(testHasEnded), 64'd0);
        checkOutput({where, ".in_ready"}, 64'(inReady), 64'd1);
    endtask

    // Drives one cycle of inputs, steps the model and compares just after the edge.
    task automatic applyStimulus(input bit valid, input logic [FW-1:0] data, input bit ending,
                                 input bit rdy, input string where);
        inValid    = valid;
        inData     = data;
        testEnding = ending;
        outReady   = rdy;
        modelStep(valid, data, ending, rdy);
        @(posedge clk);
        #1;
        checkAll(where);
    endtask

    task automatic doReset(input string where);
        resetN     = 1'b0;
        inValid    = 1'b0;
        inData     = '0;
        testEnding = 1'b0;
        outReady   = 1'b0;
        modelReset();
        #1;
        checkResetValues(where);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        bit            seen;
        logic [WW-1:0] capWord;
        int            capCount;
        int            pops;

        resetN = 1'b0;
        doReset("t1.reset");

        for (int i = 0; i < FPW; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, "t2.feed");
        end
        checkOutput("t2.word", 64'(outWord), 64'h15555555);
        checkOutput("t2.count", 64'(outCount), 64'd15);
        checkOutput("t2.dct_count", 64'(dctCount), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, "t2.pop");

        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, FW'($urandom_range(0, 3)), 1'b0, 1'b0, "t3.fill");
        end
        checkOutput("t3.dct_count14", 64'(dctCount), 64'd14);
        checkOutput("t3.in_ready_low", 64'(inReady), 64'd0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, "t3.onepop");
        checkOutput("t3.in_ready_back", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, "t3.word5");
        checkOutput("t3.word5_count", 64'(dctCount), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, "t3.drain");
        end

        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1, "t4.feed");
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, "t4.feed");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, "t4.feed");
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, "t4.pulse");
        seen     = 1'b0;
        capWord  = '0;
        capCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (outValid && !seen) begin
                seen     = 1'b1;
                capWord  = outWord;
                capCount = int'(outCount);
            end
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, "t4.wait");
        end
        checkOutput("t4.seen", 64'(seen), 64'd1);
        checkOutput("t4.word", 64'(capWord), 64'h39);
        checkOutput("t4.count", 64'(capCount), 64'd3);
        checkOutput("t4.ended", 64'(testHasEnded), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, "t4.sticky");
        end
        checkOutput("t4.sticky_end", 64'(testHasEnded), 64'd1);

        doReset("t5.reset");
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, "t5.edge0");
        checkOutput("t5.edge0_end", 64'(testHasEnded), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, "t5.edge1");
        checkOutput("t5.edge1_end", 64'(testHasEnded), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, "t5.edge2");
        checkOutput("t5.edge2_end", 64'(testHasEnded), 64'd1);
        checkOutput("t5.no_word", 64'(outValid), 64'd0);

        doReset("t6.reset");
        for (int i = 0; i < 60 + 5; i++) begin
            applyStimulus(1'b1, FW'($urandom_range(0, 3)), 1'b0, 1'b0, "t6.fill");
        end
        checkOutput("t6.dct_count5", 64'(dctCount), 64'd5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, "t6.stuck");
        end
        checkOutput("t6.stuck_count", 64'(dctCount), 64'd5);
        checkOutput("t6.stuck_end", 64'(testHasEnded), 64'd0);
        pops     = 0;
        capCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (outValid) begin
                pops++;
                capCount = int'(outCount);
            end
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, "t6.drain");
        end
        checkOutput("t6.pops", 64'(pops), 64'd5);
        checkOutput("t6.last_count", 64'(capCount), 64'd5);
        checkOutput("t6.ended", 64'(testHasEnded), 64'd1);

        doReset("t6b.reset");
        for (int i = 0; i < 60 + 5; i++) begin
            applyStimulus(1'b1, FW'($urandom_range(0, 3)), 1'b0, 1'b0, "t6b.fill");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, "t6b.drain");
        end
        checkOutput("t6b.mid_drain", 64'(outValid), 64'd1);
        #2;
        doReset("t6b.async");

        for (int round = 0; round < 3; round++) begin
            for (int c = 0; c < 300; c++) begin
                applyStimulus($urandom_range(0, 9) < 7, FW'($urandom_range(0, 3)), 1'b0,
                              bit'($urandom_range(0, 1)), "rand.run");
            end
            applyStimulus($urandom_range(0, 9) < 7, FW'($urandom_range(0, 3)), 1'b1,
                          bit'($urandom_range(0, 1)), "rand.ending");
            for (int c = 0; c < 20; c++) begin
                applyStimulus(bit'($urandom_range(0, 1)), FW'($urandom_range(0, 3)), 1'b0,
                              1'b1, "rand.finish");
            end
            checkOutput("rand.ended", 64'(testHasEnded), 64'd1);
            doReset("rand.reset");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
